// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Function : Moore control FSM for a multicycle MIPS-style datapath.
//            Define MC_IMM_OPS_EN to add addi/andi/ori/slti support.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               pc_en,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

`ifdef MC_IMM_OPS_EN
  localparam bit IMM_OPS_EN = 1'b1;
`else
  localparam bit IMM_OPS_EN = 1'b0;
`endif

  localparam logic [STATE_W-1:0] S_FETCH  = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMRD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWR  = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_RTEX   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB  = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BEQEX  = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JEX    = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_IMMEX  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_IMMWB  = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_FUNCT = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  logic [STATE_W-1:0] state_q, state_d;
  logic               illegal_q, illegal_d;
  logic               is_imm_op;

  assign is_imm_op = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                     (opcode == OP_ORI)  || (opcode == OP_SLTI);

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          default: begin
            if (IMM_OPS_EN && is_imm_op) state_d = S_IMMEX;
            else                         illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTEX:   state_d = S_ALUWB;
      // Without the immediate ops, IMMEX is an undefined encoding and falls to FETCH.
      S_IMMEX:  state_d = IMM_OPS_EN ? S_IMMWB : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQEX: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JEX: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IMMEX: begin
        if (IMM_OPS_EN) begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (opcode)
            OP_ANDI: ALUOp = ALU_AND;
            OP_ORI:  ALUOp = ALU_OR;
            OP_SLTI: ALUOp = ALU_SLT;
            default: ALUOp = ALU_ADD;
          endcase
        end
      end
      S_IMMWB: RegWrite = IMM_OPS_EN;
      default: ;
    endcase
  end

  assign pc_en   = PCWrite | (PCWriteCond & zero);
  assign state   = state_q;
  assign illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Function : Randomised scoreboard bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

`ifdef MC_IMM_OPS_EN
  localparam bit IMM_OPS_EN = 1'b1;
`else
  localparam bit IMM_OPS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, asb;
    logic [2:0] aluop;
    logic       pc_en, illegal;
  } exp_t;

  typedef int int_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, pc_en, illegal;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] state;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic mon_en = 1'b0;
  logic prev_illegal = 1'b0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .pc_en(pc_en), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // State walk of one instruction, derived from its class and cycle count.
  function automatic int_q_t model_states(input logic [5:0] op);
    int_q_t q;
    q.push_back(0);
    q.push_back(1);
    case (op)
      6'b100011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
      6'b101011: begin q.push_back(2); q.push_back(5); end
      6'b000000: begin q.push_back(6); q.push_back(7); end
      6'b000100: q.push_back(8);
      6'b000010: q.push_back(9);
      6'b001000, 6'b001100, 6'b001101, 6'b001010:
        if (IMM_OPS_EN) begin q.push_back(10); q.push_back(11); end
      default: ;
    endcase
    return q;
  endfunction

  function automatic exp_t model_cycle(input int st, input logic [5:0] op,
                                       input logic z, input logic ill);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0:  begin e.mr = 1; e.irw = 1; e.pcw = 1; e.asb = 2'b01; e.aluop = 3'b001; end
      1:  begin e.asb = 2'b11; e.aluop = 3'b001; end
      2:  begin e.asa = 1; e.asb = 2'b10; e.aluop = 3'b001; end
      3:  begin e.mr = 1; e.iord = 1; end
      4:  begin e.rw = 1; e.m2r = 1; end
      5:  begin e.mw = 1; e.iord = 1; end
      6:  begin e.asa = 1; e.aluop = 3'b000; end
      7:  begin e.rw = 1; e.rd = 1; end
      8:  begin e.asa = 1; e.aluop = 3'b010; e.pcwc = 1; e.pcs = 2'b01; end
      9:  begin e.pcw = 1; e.pcs = 2'b10; end
      10: begin
        e.asa = 1; e.asb = 2'b10;
        e.aluop = (op == 6'b001000) ? 3'b001 : (op == 6'b001100) ? 3'b011 :
                  (op == 6'b001101) ? 3'b100 : 3'b101;
      end
      11: e.rw = 1;
      default: ;
    endcase
    e.pc_en   = e.pcw | (e.pcwc & z);
    e.illegal = ill;
    return e;
  endfunction

  // abort_at > 0: reset is raised during that cycle of the instruction (1-based).
  task automatic run_instr(input logic [5:0] op, input logic z, input int abort_at);
    int_q_t sts;
    int     n;
    sts = model_states(op);
    n = (abort_at > 0) ? abort_at : sts.size();
    opcode = op;
    zero   = z;
    for (int i = 0; i < n; i++)
      exp_q.push_back(model_cycle(sts[i], op, z, (i == 0) && prev_illegal));
    if (abort_at > 0) begin
      repeat (n - 1) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      prev_illegal = 1'b0;
    end else begin
      repeat (n) @(posedge clk);
      #1;
      prev_illegal = (sts.size() == 2);
    end
  endtask

  always @(negedge clk) begin
    exp_t e, act;
    if (mon_en) begin
      cyc++;
      act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
             IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
             pc_en, illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow cycle %0d: DUT state %0d with no expected entry", cyc, state);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL cycle %0d outputs: got %h (state %0d) expected %h (state %0d)",
                   cyc, act, act.st, e, e.st);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op;
    reset  = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state %0d illegal %b expected 0 0", state, illegal);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    run_instr(6'b100011, 1'b0, 0);   // lw
    run_instr(6'b000000, 1'b1, 0);   // R-type
    run_instr(6'b000100, 1'b1, 0);   // beq taken
    run_instr(6'b000100, 1'b0, 0);   // beq not taken
    run_instr(6'b111111, 1'b0, 0);   // illegal
    run_instr(6'b001101, 1'b1, 0);   // ori
    run_instr(6'b101011, 1'b0, 0);   // sw
    run_instr(6'b000010, 1'b1, 0);   // j
    run_instr(6'b100011, 1'b0, 4);   // lw aborted in MEMRD
    run_instr(6'b111111, 1'b0, 2);   // illegal aborted in DECODE
    run_instr(6'b000000, 1'b0, 0);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        6: op = 6'b001100;
        7: op = 6'b001101;
        8: op = 6'b001010;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0 && op == 6'b100011)
        run_instr(op, 1'($urandom), int'($urandom_range(1, 5)));
      else
        run_instr(op, 1'($urandom), 0);
    end
    run_instr(6'b000000, 1'b0, 0);

    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: STATE_W, 4, width of the state register and of the state debug output.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: opcode  input  6  instruction opcode from IR; held stable by IR outside FETCH.
REQ-005 Port: zero  input  1  ALU zero flag.
REQ-006 Ports, each output 1: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst.
REQ-007 Ports: PCSource  output  2; ALUSrcB  output  2; ALUOp  output  3, feeds the ALU_control block.
REQ-008 Port: pc_en  output  1  = PCWrite | (PCWriteCond & zero), combinational.
REQ-009 Port: state  output  STATE_W  current state encoding, for debug.
REQ-010 Port: illegal  output  1  registered one-cycle flag for an unsupported opcode.

Function
REQ-011 Moore FSM; all outputs except pc_en decode from the current state only. Outputs not listed for a state are 0.
REQ-012 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, ALUWB 7, BEQEX 8, JEX 9, IMMEX 10, IMMWB 11; encodings 12-15 go to FETCH on the next edge.
REQ-013 ALUOp codes: 000 funct-decoded (R-type), 001 add, 010 sub, 011 and, 100 or, 101 slt.
REQ-014 FETCH: MemRead, IRWrite, PCWrite = 1; ALUSrcA 0; ALUSrcB 01; ALUOp 001; PCSource 00. Next state: DECODE.
REQ-015 DECODE: ALUSrcA 0; ALUSrcB 11; ALUOp 001. Next state by opcode: 100011/101011 -> MEMADR, 000000 -> RTEX, 000100 -> BEQEX, 000010 -> JEX, immediate opcodes -> IMMEX (REQ-025), any other -> FETCH.
REQ-016 MEMADR: ALUSrcA 1; ALUSrcB 10; ALUOp 001. Next state: MEMRD if opcode 100011, else MEMWR.
REQ-017 MEMRD: MemRead 1; IorD 1; next MEMWB. MEMWB: RegWrite 1; MemtoReg 1; RegDst 0; next FETCH.
REQ-018 MEMWR: MemWrite 1; IorD 1; next FETCH.
REQ-019 RTEX: ALUSrcA 1; ALUSrcB 00; ALUOp 000; next ALUWB. ALUWB: RegWrite 1; RegDst 1; MemtoReg 0; next FETCH.
REQ-020 BEQEX: ALUSrcA 1; ALUSrcB 00; ALUOp 010; PCWriteCond 1; PCSource 01; next FETCH.
REQ-021 JEX: PCWrite 1; PCSource 10; next FETCH.
REQ-022 Instruction cycle counts, FETCH included: lw 5, sw 4, R-type 4, beq 3, j 3, immediate 4, illegal 2.
REQ-023 illegal is set on the edge leaving DECODE with an unsupported opcode, so it is high during the following FETCH cycle only. It is 0 at all other times.

Reset
REQ-024 When reset is high at a rising edge, state <= FETCH and illegal <= 0. This applies in any state, including mid-instruction. An interrupted instruction is abandoned, with no further writes. FETCH outputs appear in the first cycle after reset is released.

Configuration
REQ-025 With macro MC_IMM_OPS_EN defined:
- 001000 (addi), 001100 (andi), 001101 (ori) and 001010 (slti) go from DECODE to IMMEX.
- IMMEX: ALUSrcA 1; ALUSrcB 10; ALUOp 001/011/100/101 respectively; next IMMWB.
- IMMWB: RegWrite 1; RegDst 0; MemtoReg 0; next FETCH.
REQ-026 Without MC_IMM_OPS_EN, those four opcodes are illegal per REQ-015 and REQ-023. IMMEX and IMMWB then behave as undefined encodings and go to FETCH.

Verification
REQ-027 reset high 2 cycles, then opcode 100011 -> state sequence 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
REQ-028 opcode 000000 -> states 0,1,6,7,0; ALUOp=000 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-029 opcode 000100 with zero=1, then with zero=0 -> state 8 both times; ALUOp=010; pc_en=1 only when zero=1.
REQ-030 opcode 111111 -> states 0,1,0; illegal=1 for exactly the one FETCH cycle; no RegWrite or MemWrite.
REQ-031 opcode 001101 -> with MC_IMM_OPS_EN: states 0,1,10,11,0 and ALUOp=100 in state 10; without it: identical to REQ-030.
REQ-032 reset asserted while in MEMRD (state 3) -> state 0 on the next edge; MemWrite and RegWrite never assert.
